// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Control FSM for a multicycle RV-style datapath:
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH.
//   A bad opcode or a memory timeout parks the FSM in TRAP until reset.
//
// Parameters
//   ALUOP_W  ALUOp width (3..8). Only bits [2:0] carry a code; the rest are 0.
//   TIMEOUT  maximum cycles an outstanding memory request waits for its ack.
//
// Ports
//   clk, reset_n          clock; asynchronous active-low reset
//   halt                  suppresses issuing a new instruction fetch
//   Opcode[6:0]           instruction[6:0], sampled in DECODE
//   imem_ack, dmem_ack    memory completion, ignored while the request is low
//   imem_req, dmem_req    level-held memory requests
//   ir_write, pc_write    single-cycle load strobes
//   ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp
//                         datapath controls
//   illegal, timeout      sticky error flags
//   state[2:0]            current FSM state
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int ALUOP_W = 3,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               halt,
    input  logic [6:0]         Opcode,
    input  logic               imem_ack,
    input  logic               dmem_ack,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               ir_write,
    output logic               pc_write,
    output logic               ALUSrc,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               Branch,
    output logic               Jump,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               illegal,
    output logic               timeout,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // The wait counter "reaches" TIMEOUT in the cycle where it would step to
    // TIMEOUT; that cycle is the last one the request is held.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BR, OP_IMM,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_code(input logic [6:0] op);
        case (op)
            OP_BR:             alu_code = 3'b001;
            OP_R:              alu_code = 3'b010;
            OP_IMM:            alu_code = 3'b011;
            OP_JAL, OP_JALR:   alu_code = 3'b100;
            OP_LUI, OP_AUIPC:  alu_code = 3'b101;
            default:           alu_code = 3'b000;  // LW/SW address add
        endcase
    endfunction

    state_t               state_q, state_d;
    logic [6:0]           opcode_q, opcode_d;
    logic [7:0]           wait_cnt_q, wait_cnt_d;
    logic                 imem_req_q, imem_req_d;
    logic                 dmem_req_q, dmem_req_d;
    logic                 illegal_q, illegal_d;
    logic                 timeout_q, timeout_d;
    logic                 pc_write_q, pc_write_d;
    logic                 alu_src_q, alu_src_d;
    logic                 mem_to_reg_q, mem_to_reg_d;
    logic                 reg_write_q, reg_write_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic                 branch_q, branch_d;
    logic                 jump_q, jump_d;
    logic [ALUOP_W-1:0]   alu_op_q, alu_op_d;

    logic                 ir_write_c;    // ack-qualified strobe, same cycle as imem_ack
    logic                 pc_write_ack;  // SW completion strobe, same cycle as dmem_ack
    logic                 start_fetch;   // FSM returns to FETCH at this edge
    logic [2:0]           alu3;

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        wait_cnt_d   = wait_cnt_q;
        imem_req_d   = imem_req_q;
        dmem_req_d   = dmem_req_q;
        illegal_d    = illegal_q;
        timeout_d    = timeout_q;
        ir_write_c   = 1'b0;
        pc_write_ack = 1'b0;
        start_fetch  = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (imem_req_q) begin
                    if (imem_ack) begin
                        ir_write_c = 1'b1;
                        imem_req_d = 1'b0;
                        state_d    = S_DECODE;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        imem_req_d = 1'b0;
                        timeout_d  = 1'b1;
                        state_d    = S_TRAP;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else if (!halt) begin
                    imem_req_d = 1'b1;
                    wait_cnt_d = 8'd0;
                end
            end
            S_DECODE: begin
                // Instruction register was loaded at the FETCH ack edge, so the
                // opcode is captured here and the branch uses the live input.
                opcode_d = Opcode;
                if (is_legal(Opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_EXEC: begin
                if (opcode_q == OP_LW || opcode_q == OP_SW) begin
                    dmem_req_d = 1'b1;
                    wait_cnt_d = 8'd0;
                    state_d    = S_MEM;
                end else if (opcode_q == OP_BR) begin
                    start_fetch = 1'b1;
                    state_d     = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_req_q) begin
                    if (dmem_ack) begin
                        dmem_req_d = 1'b0;
                        if (opcode_q == OP_SW) begin
                            pc_write_ack = 1'b1;
                            start_fetch  = 1'b1;
                            state_d      = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        dmem_req_d = 1'b0;
                        timeout_d  = 1'b1;
                        state_d    = S_TRAP;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            S_WB: begin
                start_fetch = 1'b1;
                state_d     = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                imem_req_d = 1'b0;
                dmem_req_d = 1'b0;
                state_d    = S_TRAP;
            end
        endcase

        // Re-entering FETCH issues the next request immediately unless halted,
        // so a normal instruction spends no idle cycle in FETCH.
        if (start_fetch && !halt) begin
            imem_req_d = 1'b1;
            wait_cnt_d = 8'd0;
        end

        // Moore controls, registered: evaluated for the state being entered.
        alu3         = 3'b000;
        alu_src_d    = 1'b0;
        mem_to_reg_d = 1'b0;
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        branch_d     = 1'b0;
        jump_d       = 1'b0;
        pc_write_d   = 1'b0;
        case (state_d)
            S_EXEC: begin
                alu3      = alu_code(opcode_d);
                alu_src_d = (opcode_d == OP_LW)   || (opcode_d == OP_SW)  ||
                            (opcode_d == OP_IMM)  || (opcode_d == OP_JALR) ||
                            (opcode_d == OP_LUI)  || (opcode_d == OP_AUIPC);
                branch_d  = (opcode_d == OP_BR) || (opcode_d == OP_JAL) ||
                            (opcode_d == OP_JALR);
                jump_d    = (opcode_d == OP_JAL) || (opcode_d == OP_JALR);
                pc_write_d = (opcode_d == OP_BR);
            end
            S_MEM: begin
                mem_read_d  = (opcode_d == OP_LW);
                mem_write_d = (opcode_d == OP_SW);
            end
            S_WB: begin
                reg_write_d  = 1'b1;
                pc_write_d   = 1'b1;
                mem_to_reg_d = (opcode_d == OP_LW);
                jump_d       = (opcode_d == OP_JAL) || (opcode_d == OP_JALR);
            end
            default: ;
        endcase
        alu_op_d = ALUOP_W'(alu3);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_FETCH;
            opcode_q     <= 7'd0;
            wait_cnt_q   <= 8'd0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
            pc_write_q   <= 1'b0;
            alu_src_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
            jump_q       <= 1'b0;
            alu_op_q     <= '0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            wait_cnt_q   <= wait_cnt_d;
            imem_req_q   <= imem_req_d;
            dmem_req_q   <= dmem_req_d;
            illegal_q    <= illegal_d;
            timeout_q    <= timeout_d;
            pc_write_q   <= pc_write_d;
            alu_src_q    <= alu_src_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            branch_q     <= branch_d;
            jump_q       <= jump_d;
            alu_op_q     <= alu_op_d;
        end
    end

    // Strobes qualified by an ack are only possible while the request flop is
    // high, so they are 0 during reset along with every registered output.
    assign imem_req = imem_req_q;
    assign dmem_req = dmem_req_q;
    assign ir_write = ir_write_c;
    assign pc_write = pc_write_q | pc_write_ack;
    assign ALUSrc   = alu_src_q;
    assign MemtoReg = mem_to_reg_q;
    assign RegWrite = reg_write_q;
    assign MemRead  = mem_read_q;
    assign MemWrite = mem_write_q;
    assign Branch   = branch_q;
    assign Jump     = jump_q;
    assign ALUOp    = alu_op_q;
    assign illegal  = illegal_q;
    assign timeout  = timeout_q;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//   Builds an expected per-cycle trace for each instruction from the opcode
//   tables and the cycle budget of every instruction class, then replays it
//   against the controller (inputs set on the falling edge, outputs checked
//   1 time unit later). Acks are randomized whenever no request is expected
//   and the opcode input is randomized outside DECODE.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam int TO = 4;
    localparam int AW = 5;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          halt = 1'b0;
    logic [6:0]    Opcode = 7'd0;
    logic          imem_ack = 1'b0;
    logic          dmem_ack = 1'b0;
    logic          imem_req, dmem_req, ir_write, pc_write;
    logic          ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump;
    logic [AW-1:0] ALUOp;
    logic          illegal, timeout;
    logic [2:0]    state;

    always #5 clk = ~clk;

    multicycle_controller #(.ALUOP_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .halt(halt), .Opcode(Opcode),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req),
        .ir_write(ir_write), .pc_write(pc_write),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump),
        .ALUOp(ALUOp), .illegal(illegal), .timeout(timeout), .state(state)
    );

    // {state, imem_req, dmem_req, ir_write, pc_write, ALUSrc, MemtoReg,
    //  RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp[4:0], illegal, timeout}
    logic [20:0] obs;
    assign obs = {state, imem_req, dmem_req, ir_write, pc_write, ALUSrc, MemtoReg,
                  RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp, illegal, timeout};

    typedef struct {
        logic        rst;
        logic        halt;
        logic        iack;
        logic        dack;
        logic [6:0]  opc;
        logic [20:0] exp;
        string       tag;
    } ent_t;

    ent_t trace[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic [6:0] legal_ops [9] = '{OP_R, OP_LW, OP_SW, OP_BR, OP_IMM,
                                  OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    task automatic check_vec(input string tag, input logic [20:0] got, input logic [20:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, got, want);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] r7();
        return 7'($urandom);
    endfunction

    function automatic logic [20:0] mk(input logic [2:0] st, input logic ireq, input logic dreq,
                                       input logic irw, input logic pcw, input logic asrc,
                                       input logic m2r, input logic rw, input logic mr,
                                       input logic mw, input logic br, input logic jp,
                                       input logic [2:0] aop, input logic ill, input logic tmo);
        return {st, ireq, dreq, irw, pcw, asrc, m2r, rw, mr, mw, br, jp, {2'b00, aop}, ill, tmo};
    endfunction

    task automatic push(input string tag, input logic rst, input logic h, input logic ia,
                        input logic da, input logic [6:0] op, input logic [20:0] e);
        ent_t x;
        x.rst = rst; x.halt = h; x.iack = ia; x.dack = da; x.opc = op; x.exp = e; x.tag = tag;
        trace.push_back(x);
    endtask

    // Opcode class table: ALUOp code, ALUSrc, Branch, Jump, load, store, BR, legal.
    task automatic classify(input logic [6:0] op, output logic [2:0] aop, output logic asrc,
                            output logic br, output logic jp, output logic ld,
                            output logic st, output logic bra, output logic ok);
        aop = 3'd0; asrc = 0; br = 0; jp = 0; ld = 0; st = 0; bra = 0; ok = 1;
        case (op)
            OP_R:     aop = 3'd2;
            OP_LW:    begin asrc = 1; ld = 1; end
            OP_SW:    begin asrc = 1; st = 1; end
            OP_BR:    begin aop = 3'd1; br = 1; bra = 1; end
            OP_IMM:   begin aop = 3'd3; asrc = 1; end
            OP_JAL:   begin aop = 3'd4; br = 1; jp = 1; end
            OP_JALR:  begin aop = 3'd4; asrc = 1; br = 1; jp = 1; end
            OP_LUI:   begin aop = 3'd5; asrc = 1; end
            OP_AUIPC: begin aop = 3'd5; asrc = 1; end
            default:  ok = 0;
        endcase
    endtask

    task automatic push_trap(input logic ill, input logic tmo, input int n);
        for (int i = 0; i < n; i++)
            push("trap", 0, rb(), rb(), rb(), r7(), mk(3'd5, 0,0,0,0,0,0,0,0,0,0,0, 3'd0, ill, tmo));
    endtask

    // Reset cycle (checked without any clock edge), then n idle FETCH cycles
    // with no request; halt is held for all but the last of them.
    task automatic push_reset(input int n);
        push("reset", 1, rb(), rb(), rb(), r7(), 21'd0);
        for (int i = 0; i < n; i++)
            push("idle", 0, (i < n - 1), rb(), rb(), r7(), 21'd0);
    endtask

    // Halt at the edge that returns to FETCH, then n halted idle cycles.
    task automatic push_idle(input int n);
        trace[trace.size() - 1].halt = 1'b1;
        for (int i = 0; i < n; i++)
            push("halted", 0, (i < n - 1), rb(), rb(), r7(), 21'd0);
    endtask

    // One instruction starting in FETCH with imem_req already high.
    // fd/md: cycles before the ack (>= TO means the ack never comes).
    // hm: halt held high while the fetch is outstanding. cut: stop after the
    // first MEM cycle (a reset follows).
    task automatic push_instr(input logic [6:0] op, input int fd, input int md,
                              input logic hm, input logic cut);
        logic [2:0] aop;
        logic asrc, br, jp, ld, st, bra, ok;
        classify(op, aop, asrc, br, jp, ld, st, bra, ok);
        for (int i = 0; i < fd && i < TO; i++)
            push("fetch_wait", 0, hm, 0, rb(), r7(), mk(3'd0, 1,0,0,0,0,0,0,0,0,0,0, 3'd0, 0, 0));
        if (fd >= TO) begin
            push_trap(0, 1, 6);
            return;
        end
        push("fetch_ack", 0, hm, 1, rb(), r7(), mk(3'd0, 1,0,1,0,0,0,0,0,0,0,0, 3'd0, 0, 0));
        push("decode", 0, rb(), rb(), rb(), op, mk(3'd1, 0,0,0,0,0,0,0,0,0,0,0, 3'd0, 0, 0));
        if (!ok) begin
            push_trap(1, 0, 20);
            return;
        end
        push("exec", 0, rb(), rb(), rb(), r7(), mk(3'd2, 0,0,0,bra,asrc,0,0,0,0,br,jp, aop, 0, 0));
        if (ld || st) begin
            for (int i = 0; i < md && i < TO; i++) begin
                push("mem_wait", 0, rb(), rb(), 0, r7(), mk(3'd3, 0,1,0,0,0,0,0,ld,st,0,0, 3'd0, 0, 0));
                if (cut) return;
            end
            if (md >= TO) begin
                push_trap(0, 1, 5);
                return;
            end
            push("mem_ack", 0, rb(), rb(), 1, r7(), mk(3'd3, 0,1,0,st,0,0,0,ld,st,0,0, 3'd0, 0, 0));
        end
        if (!bra && !st)
            push("wb", 0, rb(), rb(), rb(), r7(), mk(3'd4, 0,0,0,1,0,ld,1,0,0,0,jp, 3'd0, 0, 0));
        trace[trace.size() - 1].halt = 1'b0;
    endtask

    initial begin
        ent_t e;
        push_reset(1);
        push_instr(OP_R, 2, 0, 0, 0);          // R with ack two cycles after req
        push_instr(OP_LW, 0, 3, 0, 0);         // LW, dmem_ack in 4th MEM cycle
        push_idle(3);                          // halt with nothing outstanding
        push_instr(OP_IMM, 3, 0, 1, 0);        // halt mid-request, ack in 4th (last) cycle
        push_instr(OP_SW, 3, 3, 0, 0);
        push_instr(OP_BR, 0, 0, 0, 0);
        for (int k = 0; k < 30; k++) begin
            push_instr(legal_ops[$urandom_range(0, 8)], $urandom_range(0, 3),
                       $urandom_range(0, 3), rb(), 0);
            if ($urandom_range(0, 4) == 0) push_idle($urandom_range(1, 3));
        end
        push_instr(OP_SW, 1, 3, 0, 1);          // reset while SW is in MEM
        push_reset(1);
        push_instr(7'b1111111, 0, 0, 0, 0);    // illegal -> TRAP for 20 cycles
        push_reset(3);                          // halt held right after reset
        push_instr(OP_R, TO + 5, 0, 0, 0);     // imem never acks -> timeout
        push_reset(1);
        push_instr(OP_LW, 1, TO + 5, 0, 0);    // dmem never acks -> timeout
        push_reset(1);
        push_instr(OP_JAL, 1, 0, 0, 0);
        push_instr(OP_JALR, 0, 0, 0, 0);
        push_instr(OP_LUI, 2, 0, 0, 0);
        push_instr(OP_AUIPC, 0, 0, 0, 0);

        while (trace.size() > 0) begin
            e = trace.pop_front();
            @(negedge clk);
            cyc++;
            reset_n  = !e.rst;
            halt     = e.halt;
            imem_ack = e.iack;
            dmem_ack = e.dack;
            Opcode   = e.opc;
            #1;
            check_vec(e.tag, obs, e.exp);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter ALUOP_W, default 3, SHALL set the ALUOp width; legal values are 3 to 8, and bits above [2] SHALL be driven 0.
REQ-002 Parameter TIMEOUT, default 15, SHALL set the maximum cycles an outstanding memory request waits for its ack; legal values are 1 to 255.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 halt  in  1  when 1, no new instruction fetch is issued.
REQ-006 Opcode  in  7  instruction[6:0] from the instruction register; valid in DECODE.
REQ-007 imem_ack  in  1  instruction memory done; dmem_ack  in  1  data memory done.
REQ-008 imem_req  out  1; dmem_req  out  1  memory request, level-held until the matching ack.
REQ-009 ir_write  out  1; pc_write  out  1  single-cycle load strobes.
REQ-010 ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump  out  1 each; ALUOp  out  ALUOP_W.
REQ-011 illegal  out  1  sticky bad opcode; timeout  out  1  sticky memory timeout; state  out  3  current FSM state.

Function
REQ-012 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5, encoded on the state output.
REQ-013 All control outputs SHALL be a Moore function of the state and a 7-bit opcode register latched on DECODE entry; opcode changes outside DECODE SHALL have no effect.
REQ-014 FETCH: imem_req SHALL be asserted when halt=0 or when a request is already outstanding; once asserted it SHALL hold until imem_ack, regardless of halt.
REQ-015 FETCH with imem_req=1 and imem_ack=1 in the same cycle: ir_write SHALL pulse that cycle, and the FSM SHALL enter DECODE next; an ack arriving in the first cycle of the request SHALL be accepted.
REQ-016 imem_ack or dmem_ack arriving while the matching request is low SHALL be ignored.
REQ-017 DECODE (1 cycle): the legal opcodes are 0110011 (R), 0000011 (LW), 0100011 (SW), 1100011 (BR), 0010011 (IMM), 1101111 (JAL), 1100111 (JALR), 0110111 (LUI) and 0010111 (AUIPC).
REQ-018 DECODE: a legal opcode SHALL go to EXEC; any other opcode SHALL go to TRAP and set illegal.
REQ-019 EXEC (1 cycle) SHALL drive ALUOp as follows: LW/SW=000, BR=001, R=010, IMM=011, JAL/JALR=100, LUI/AUIPC=101.
REQ-020 EXEC SHALL drive ALUSrc=1 for LW, SW, IMM, JALR, LUI and AUIPC.
REQ-021 EXEC SHALL drive Branch=1 for BR, JAL and JALR, and Jump=1 for JAL and JALR.
REQ-022 EXEC next state: LW/SW go to MEM; BR asserts pc_write and goes to FETCH; all other legal opcodes go to WB.
REQ-023 MEM SHALL hold dmem_req, with MemRead=1 (LW) or MemWrite=1 (SW), until dmem_ack.
REQ-024 MEM on ack: LW SHALL go to WB; SW SHALL assert pc_write and go to FETCH.
REQ-025 WB (1 cycle) SHALL assert RegWrite=1 and pc_write=1, and MemtoReg=1 only for LW, then go to FETCH; Jump SHALL also be held 1 in WB for JAL/JALR.
REQ-026 Outside the states named in REQ-019 to REQ-025, each control output SHALL be 0.
REQ-027 An 8-bit wait counter SHALL clear on each new request and increment each cycle a request is outstanding without ack.
REQ-028 When the wait counter reaches TIMEOUT, the FSM SHALL enter TRAP next cycle, set timeout, and drop the request.
REQ-029 An ack in the same cycle the counter reaches TIMEOUT SHALL win: normal progress, no timeout.
REQ-030 TRAP SHALL drive every control, request and strobe output 0, and SHALL be left only by reset.
REQ-031 Each instruction SHALL take the following cycles, with memory wait included: R/IMM/LUI/AUIPC/JAL/JALR = FETCH+3, BR = FETCH+2, SW = FETCH+MEM+2, LW = FETCH+MEM+3.

Reset
REQ-032 reset_n=0 SHALL immediately force state=FETCH, clear the opcode register, wait counter, illegal and timeout, and drive every output 0, including requests in flight.
REQ-033 After reset_n rises, the first imem_req SHALL appear on the first clock edge with halt=0.

Verification
REQ-034 R-type 0110011, imem_ack 2 cycles after req -> state sequence 0,0,0,1,2,4,0; ALUOp=010 in EXEC; RegWrite=1 and pc_write=1 in WB only.
REQ-035 LW with dmem_ack delayed 3 cycles -> MemRead=1 and dmem_req=1 for 4 MEM cycles; WB with MemtoReg=1 and RegWrite=1.
REQ-036 Opcode 1111111 -> DECODE then TRAP; illegal=1; all outputs 0 for 20 cycles, until reset.
REQ-037 TIMEOUT=4 with imem_ack never asserted -> imem_req high 4 cycles, then state=5 and timeout=1; repeat with ack in the 4th cycle -> DECODE, timeout=0.
REQ-038 halt=1 with no request outstanding -> imem_req stays 0; halt raised mid-request -> imem_req held until ack.
REQ-039 reset_n pulsed low during MEM of SW -> dmem_req and MemWrite go 0 asynchronously; state=0 and illegal=timeout=0 after release.
